// File: rtl/crm_word_pipe.sv
// crm_word_pipe: control-RAM microword pipeline register with three-field diagnostic load/readback.
// Build macro CRM_PARITY_EN adds an odd-parity bit per stored word and a sticky fetch parity error.
module crm_word_pipe #(
    parameter int unsigned ADR_W   = 11,
    parameter int unsigned FIELD_W = 28,
    parameter int unsigned WORD_W  = 3 * FIELD_W
) (
    input  logic               clk_crm_h,
    input  logic               mr_reset_l,
    input  logic [ADR_W-1:0]   cra_adr_h,
    input  logic               crm_run_h,
    input  logic               diag_load_h,
    input  logic [1:0]         diag_field_h,
    input  logic [FIELD_W-1:0] diag_data_h,
    input  logic               diag_read_h,
    output logic [WORD_W-1:0]  cram_word_h,
    output logic [FIELD_W-1:0] ebus_crm_h,
    output logic               diag_busy_h,
    output logic               cram_par_err_h
);
`ifdef CRM_PARITY_EN
    localparam int unsigned MEM_W = WORD_W + 1;
`else
    localparam int unsigned MEM_W = WORD_W;
`endif
    localparam int unsigned DEPTH = 1 << ADR_W;

    typedef enum logic [1:0] {StIdle, StCollect, StCommit, StVerify} state_e;

    state_e             state_q;
    logic [2:0]         mask_q;
    logic [WORD_W-1:0]  staging_q;
    logic [MEM_W-1:0]   mem [DEPTH];

    logic [MEM_W-1:0]   rd_word;
    logic [MEM_W-1:0]   wr_word;
    logic               par_bad;
    logic               fetch;
    logic               load_ok;
    logic               clear_ok;
    logic [2:0]         mask_set;
    logic [FIELD_W-1:0] read_mux;

    assign rd_word  = mem[cra_adr_h];
    assign load_ok  = diag_load_h && !crm_run_h && !diag_busy_h && (diag_field_h != 2'd3);
    assign clear_ok = diag_load_h && (diag_field_h == 2'd3);
    assign mask_set = mask_q | (3'b001 << diag_field_h);
    // COMMIT suppresses the run fetch; VERIFY always reloads the freshly written word.
    assign fetch    = (crm_run_h && (state_q == StIdle || state_q == StCollect))
                   || (state_q == StVerify);

`ifdef CRM_PARITY_EN
    assign wr_word = {~^staging_q, staging_q};
    assign par_bad = ~^rd_word;
`else
    assign wr_word = staging_q;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        read_mux = '0;
        case (diag_field_h)
            2'd0:    read_mux = cram_word_h[0*FIELD_W +: FIELD_W];
            2'd1:    read_mux = cram_word_h[1*FIELD_W +: FIELD_W];
            2'd2:    read_mux = cram_word_h[2*FIELD_W +: FIELD_W];
            default: read_mux = {{(FIELD_W-5){1'b0}}, diag_busy_h, mask_q, cram_par_err_h};
        endcase
    end

    // Store is not reset; a reset during COMMIT forces IDLE first, so no write happens.
    always_ff @(posedge clk_crm_h) begin
        if (state_q == StCommit) begin
            mem[cra_adr_h] <= wr_word;
        end
    end

    always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q        <= StIdle;
            mask_q         <= '0;
            staging_q      <= '0;
            cram_word_h    <= '0;
            ebus_crm_h     <= '0;
            diag_busy_h    <= 1'b0;
            cram_par_err_h <= 1'b0;
        end else begin
            if (fetch) begin
                cram_word_h <= rd_word[WORD_W-1:0];
            end
            if (diag_read_h) begin
                ebus_crm_h <= read_mux;
            end
            if (fetch && par_bad) begin
                cram_par_err_h <= 1'b1;
            end else if (clear_ok) begin
                cram_par_err_h <= 1'b0;
            end

            unique case (state_q)
                StIdle, StCollect: begin
                    if (crm_run_h) begin
                        state_q   <= StIdle;
                        mask_q    <= '0;
                        staging_q <= '0;
                    end else if (clear_ok) begin
                        state_q <= StIdle;
                        mask_q  <= '0;
                    end else if (load_ok) begin
                        case (diag_field_h)
                            2'd0:    staging_q[0*FIELD_W +: FIELD_W] <= diag_data_h;
                            2'd1:    staging_q[1*FIELD_W +: FIELD_W] <= diag_data_h;
                            default: staging_q[2*FIELD_W +: FIELD_W] <= diag_data_h;
                        endcase
                        mask_q <= mask_set;
                        if (mask_set == 3'b111) begin
                            state_q     <= StCommit;
                            diag_busy_h <= 1'b1;
                        end else begin
                            state_q <= StCollect;
                        end
                    end
                end
                StCommit: begin
                    state_q <= StVerify;
                    mask_q  <= '0;
                end
                StVerify: begin
                    state_q     <= StIdle;
                    diag_busy_h <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    diag_busy_h <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crm_word_pipe.sv
// Scoreboard bench for crm_word_pipe: directed and random diagnostic commits, run fetches and
// readbacks, each predicted by a behavioural store model and checked by a separate monitor.
module tb_crm_word_pipe;
    localparam int ADR_W   = 11;
    localparam int FIELD_W = 28;
    localparam int WORD_W  = 84;

    logic               clk = 1'b0;
    logic               rst_l;
    logic [ADR_W-1:0]   cra_adr;
    logic               run;
    logic               dload;
    logic [1:0]         dfield;
    logic [FIELD_W-1:0] ddata;
    logic               dread;
    logic [WORD_W-1:0]  cram_word;
    logic [FIELD_W-1:0] ebus;
    logic               busy;
    logic               par_err;

    crm_word_pipe dut (
        .clk_crm_h     (clk),
        .mr_reset_l    (rst_l),
        .cra_adr_h     (cra_adr),
        .crm_run_h     (run),
        .diag_load_h   (dload),
        .diag_field_h  (dfield),
        .diag_data_h   (ddata),
        .diag_read_h   (dread),
        .cram_word_h   (cram_word),
        .ebus_crm_h    (ebus),
        .diag_busy_h   (busy),
        .cram_par_err_h(par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        int                kind;
        logic [WORD_W-1:0] val;
    } exp_t;

    exp_t               exp_q[$];
    int                 total = 0;
    int                 bad   = 0;
    int                 cyc   = 0;
    string              kname[4] = '{"cram_word", "ebus", "busy", "par_err"};

    // Behavioural model: an associative store plus the expected visible word and staging.
    logic [WORD_W-1:0]  model_mem [int];
    int                 written[$];
    logic [WORD_W-1:0]  model_word = '0;
    logic [FIELD_W-1:0] model_stage[3];
    logic [2:0]         model_mask = '0;

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic push(input int off, input int kind, input logic [WORD_W-1:0] v);
        exp_t e;
        e.due  = cyc + off;
        e.kind = kind;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    function automatic logic [WORD_W-1:0] rb_model(input int f);
        logic [WORD_W-1:0] r;
        r = '0;
        if (f < 3) r[FIELD_W-1:0] = model_word[f*FIELD_W +: FIELD_W];
        else       r[4:0] = {1'b0, model_mask, 1'b0};
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[WORD_W-1:0];
    endfunction

    function automatic logic [FIELD_W-1:0] rand_field();
        logic [31:0] r;
        r = $urandom();
        return r[FIELD_W-1:0];
    endfunction

    // Monitor: samples 1 time unit after each rising edge and retires due expectations.
    initial begin
        exp_t              e;
        logic [WORD_W-1:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e   = exp_q.pop_front();
                act = '0;
                case (e.kind)
                    0:       act = cram_word;
                    1:       act[FIELD_W-1:0] = ebus;
                    2:       act[0] = busy;
                    default: act[0] = par_err;
                endcase
                check(kname[e.kind], act, e.val);
            end
        end
    end

    // One diagnostic field load, optionally with a same-cycle readback of that field.
    task automatic load(input int adr, input int f, input logic [FIELD_W-1:0] d,
                        input bit do_read);
        logic [WORD_W-1:0] w;
        cra_adr = ADR_W'(adr);
        dload   = 1'b1;
        dfield  = 2'(f);
        ddata   = d;
        dread   = do_read;
        if (do_read) push(1, 1, rb_model(f));
        model_stage[f] = d;
        model_mask     = model_mask | 3'(1 << f);
        @(negedge clk);
        dload = 1'b0;
        dread = 1'b0;
        if (model_mask == 3'b111) begin
            w = {model_stage[2], model_stage[1], model_stage[0]};
            if (!model_mem.exists(adr)) written.push_back(adr);
            model_mem[adr] = w;
            model_word     = w;
            model_mask     = '0;
            push(0, 2, 1);
            push(1, 2, 1);
            push(2, 2, 0);
            push(2, 0, w);
            push(2, 3, 0);
            // Loads during the busy window must be ignored.
            dload  = 1'b1;
            dfield = 2'd0;
            ddata  = rand_field();
            repeat (2) @(negedge clk);
            dload = 1'b0;
        end
    endtask

    task automatic commit(input int adr, input logic [WORD_W-1:0] w);
        load(adr, 0, w[0*FIELD_W +: FIELD_W], 1'b0);
        load(adr, 1, w[1*FIELD_W +: FIELD_W], 1'b0);
        load(adr, 2, w[2*FIELD_W +: FIELD_W], 1'b0);
    endtask

    task automatic fetch_one(input int adr, input bit junk_load);
        run     = 1'b1;
        cra_adr = ADR_W'(adr);
        dload   = junk_load;
        dfield  = 2'($urandom_range(0, 2));
        ddata   = rand_field();
        model_mask = '0;
        model_word = model_mem[adr];
        push(1, 0, model_word);
        push(1, 3, 0);
        @(negedge clk);
        dload = 1'b0;
    endtask

    task automatic stop_run();
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic read(input int f);
        dread  = 1'b1;
        dfield = 2'(f);
        push(1, 1, rb_model(f));
        @(negedge clk);
        dread = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        check("queue_drained", WORD_W'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] w9;
        int                perm[3];
        int                a;

        rst_l = 1'b0; cra_adr = '0; run = 1'b0; dload = 1'b0;
        dfield = '0; ddata = '0; dread = 1'b0;
        #1;
        check("reset_word", cram_word, '0);
        check("reset_ebus", WORD_W'(ebus), '0);
        check("reset_busy", WORD_W'(busy), '0);
        check("reset_par", WORD_W'(par_err), '0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        // Three-field commit at the top address, then read field 1.
        load(11'h7FF, 0, 28'h0000001, 1'b0);
        load(11'h7FF, 1, 28'h0ABCDEF, 1'b0);
        load(11'h7FF, 2, 28'hFFFFFFF, 1'b0);
        check("tp_word_7ff", cram_word, 84'hFFFFFFF_0ABCDEF_0000001);
        read(1);
        drain();
        check("tp_ebus_f1", WORD_W'(ebus), WORD_W'(28'h0ABCDEF));

        // Run fetch sequence 5,6,5.
        commit(5, rand_word());
        commit(6, rand_word());
        fetch_one(5, 1'b0);
        fetch_one(6, 1'b0);
        fetch_one(5, 1'b0);
        stop_run();
        drain();

        // Partial load abandoned by run.
        commit(20, rand_word());
        load(20, 0, rand_field(), 1'b0);
        load(20, 1, rand_field(), 1'b0);
        read(3);
        fetch_one(20, 1'b0);
        stop_run();
        read(3);
        read(0);
        drain();

        // Field 0 rewritten before completion: last write wins.
        load(30, 0, 28'h1, 1'b0);
        load(30, 0, 28'h2, 1'b0);
        load(30, 1, rand_field(), 1'b0);
        load(30, 2, rand_field(), 1'b0);
        check("rewrite_f0", WORD_W'(cram_word[FIELD_W-1:0]), WORD_W'(28'h2));
        drain();

        // Random commits (with shuffled order, rewrites, same-cycle reads) and fetch bursts.
        for (int it = 0; it < 16; it++) begin
            a = $urandom_range(0, (1 << ADR_W) - 1);
            perm = '{0, 1, 2};
            perm.shuffle();
            if ($urandom_range(0, 1) == 1) load(a, perm[2], rand_field(), 1'b1);
            for (int k = 0; k < 3; k++) load(a, perm[k], rand_field(), k == 0);
            for (int k = 0; k < 4; k++)
                fetch_one(written[$urandom_range(0, written.size() - 1)], $urandom_range(0, 1) == 1);
            stop_run();
            read($urandom_range(0, 3));
            read(3);
        end
        drain();

        // Reset asserted while COMMIT is pending: store keeps its old contents.
        w9 = rand_word();
        commit(9, w9);
        cra_adr = 11'd9;
        for (int k = 0; k < 3; k++) begin
            dload  = 1'b1;
            dfield = 2'(k);
            ddata  = ~w9[k*FIELD_W +: FIELD_W];
            @(negedge clk);
        end
        dload = 1'b0;
        check("commit_busy", WORD_W'(busy), WORD_W'(1'b1));
        rst_l = 1'b0;
        #1;
        check("rst_commit_busy", WORD_W'(busy), '0);
        check("rst_commit_word", cram_word, '0);
        @(negedge clk);
        rst_l      = 1'b1;
        model_word = '0;
        model_mask = '0;
        fetch_one(9, 1'b0);
        stop_run();
        read(2);
        drain();

        // Mid-cycle asynchronous reset with non-zero outputs.
        #2;
        rst_l = 1'b0;
        #1;
        check("async_rst_word", cram_word, '0);
        check("async_rst_ebus", WORD_W'(ebus), '0);
        check("async_rst_busy", WORD_W'(busy), '0);
        check("async_rst_par", WORD_W'(par_err), '0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crm_word_pipe.md
# crm_word_pipe

Control-RAM microword stage directly downstream of the CRA address logic. Each machine cycle it takes the 11-bit next microaddress produced by CRA and presents the addressed microword in a pipeline register. It also provides the diagnostic path that loads and reads the microcode store in three EBUS-sized fields. In the parity build it checks every fetched microword.

## Interface
Parameters:
- ADR_W, 11, microaddress width (2048 words)
- FIELD_W, 28, diagnostic field width
- WORD_W, 84, microword width; fixed at 3*FIELD_W

Ports:
- clk_crm_h  in  1  microcycle clock; all state changes on the rising edge
- mr_reset_l  in  1  master reset; asynchronous assert, active-low
- cra_adr_h  in  ADR_W  next microaddress from CRA; held stable by CRA while the machine is stopped
- crm_run_h  in  1  high = fetch one microword every cycle
- diag_load_h  in  1  one-cycle strobe; writes diag_data_h into staging field diag_field_h
- diag_field_h  in  2  field select 0..2; value 3 = status/clear
- diag_data_h  in  FIELD_W  diagnostic write data
- diag_read_h  in  1  strobe; latches the selected readback onto ebus_crm_h
- cram_word_h  out  WORD_W  current microword; field 0 = bits [FIELD_W-1:0]
- ebus_crm_h  out  FIELD_W  diagnostic readback
- diag_busy_h  out  1  high while a diagnostic commit or verify is in progress
- cram_par_err_h  out  1  sticky microword parity error

## Operation
- Store: 2^ADR_W x WORD_W synchronous-read RAM; it is not cleared by reset.
- Run fetch: when crm_run_h=1, cram_word_h <= mem[cra_adr_h] on each edge. When crm_run_h=0, cram_word_h holds except in VERIFY.
- Diagnostic FSM states:
  - IDLE to COLLECT: diag_load_h with field 0..2 while run=0. Writes the staging field and sets its bit in mask[2:0].
  - COLLECT: further loads overwrite the staging field and set its mask bit. Rewriting an already-loaded field is legal; the last write wins.
  - COLLECT to COMMIT: when mask==3'b111 after the edge.
  - COMMIT: one cycle. mem[cra_adr_h] <= staging; mask cleared; diag_busy_h=1.
  - VERIFY: one cycle. cram_word_h <= mem[cra_adr_h] (the new contents); diag_busy_h=1. Then IDLE.
- Load/run interlocks:
  - diag_load_h is ignored while diag_busy_h=1 or crm_run_h=1.
  - crm_run_h rising in COLLECT discards staging, clears mask and returns to IDLE.
  - crm_run_h rising in COMMIT or VERIFY lets that cycle finish. Fetch resumes the cycle after VERIFY.
- diag_load_h with field 3: clears cram_par_err_h and the staging mask; returns to IDLE unless busy.
- Readback:
  - diag_read_h with field f in 0..2: ebus_crm_h <= cram_word_h[f*FIELD_W +: FIELD_W].
  - Field 3: ebus_crm_h <= {zeros, diag_busy_h, mask, cram_par_err_h}, right-justified.
  - ebus_crm_h holds between strobes.
- diag_read_h and diag_load_h in the same cycle: both act; the readback shows the pre-edge cram_word_h.

## Timing
- Fetch latency: address valid before edge N; word valid after edge N (1 cycle).
- Diagnostic write: final field load at edge N; COMMIT during cycle N+1; VERIFY loads cram_word_h at edge N+2; diag_busy_h high for cycles N+1..N+2.
- Readback latency: 1 cycle from the diag_read_h edge.
- Reset values: cram_word_h=0, ebus_crm_h=0, diag_busy_h=0, cram_par_err_h=0, state IDLE, mask=0, staging=0.
- Reset asserted during COMMIT before the edge: the write does not occur.

## Configuration
- CRM_PARITY_EN defined:
  - Store is WORD_W+1 wide. COMMIT writes an odd-parity bit over the staging word.
  - Every run fetch and VERIFY recomputes parity. A mismatch sets cram_par_err_h on the same edge that loads the word; it stays set until reset or a field-3 load.
- CRM_PARITY_EN undefined: store is WORD_W wide; cram_par_err_h is constant 0; field-3 readback parity bit reads 0.

## Test plan
- Reset: drive mr_reset_l=0 mid-cycle -> all outputs 0 immediately, with no clock edge.
- Load fields 0,1,2 = 28'h0000001, 28'h0ABCDEF, 28'hFFFFFFF at cra_adr_h=11'h7FF, run=0 -> diag_busy_h high for 2 cycles; then cram_word_h = 84'hFFFFFFF_0ABCDEF_0000001; read field 1 -> ebus_crm_h = 28'h0ABCDEF.
- Preload addresses 5 and 6 with distinct words, then run=1 with the address sequence 5,6,5 -> cram_word_h follows one cycle later, matching each word.
- Load fields 0 and 1, then raise run -> mask cleared; address unchanged in mem; field-3 readback shows mask=0.
- Load field 0 twice (28'h1 then 28'h2), then fields 1 and 2 -> committed field 0 = 28'h2.
- CRM_PARITY_EN: force-flip one stored bit at address 3, fetch it -> cram_par_err_h=1 and stays set; field-3 load -> 0. Without the macro, the same flip -> cram_par_err_h stays 0.
